// File: rtl/vec_reg_file_if.sv
// Bus bundle for vec_reg_file: write port, registered read port and the
// element-serial drain port with its valid/ready handshake.
interface vec_reg_file_if #(
    parameter int WIDTH      = 128,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int WIDTH_ADDR_SIZE = $clog2(WIDTH);
    localparam int DEPTH_ADDR_SIZE = $clog2(DEPTH);

    logic [1:0]                  wr_op;
    logic [DEPTH_ADDR_SIZE-1:0]  wr_reg;
    logic [WIDTH_ADDR_SIZE-1:0]  wr_idx;
    logic [WIDTH*DATA_WIDTH-1:0] wr_data;

    logic [1:0]                  rd_op;
    logic [DEPTH_ADDR_SIZE-1:0]  rd_reg;
    logic [WIDTH_ADDR_SIZE-1:0]  rd_idx;
    logic [WIDTH*DATA_WIDTH-1:0] rd_data;
    logic                        rd_valid;

    logic                        stream_start;
    logic [DEPTH_ADDR_SIZE-1:0]  stream_reg;
    logic [DATA_WIDTH-1:0]       stream_data;
    logic                        stream_valid;
    logic                        stream_ready;
    logic                        stream_last;
    logic                        stream_busy;

    modport master (
        output wr_op, wr_reg, wr_idx, wr_data,
        output rd_op, rd_reg, rd_idx,
        input  rd_data, rd_valid,
        output stream_start, stream_reg, stream_ready,
        input  stream_data, stream_valid, stream_last, stream_busy
    );

    modport slave (
        input  wr_op, wr_reg, wr_idx, wr_data,
        input  rd_op, rd_reg, rd_idx,
        output rd_data, rd_valid,
        input  stream_start, stream_reg, stream_ready,
        output stream_data, stream_valid, stream_last, stream_busy
    );
endinterface

// File: rtl/vec_reg_file.sv
// Vector register file: one write port, one registered read port, one element-serial drain port.
// Define VEC_REG_FILE_BYPASS_EN to forward same-cycle write data to the read port.
module vec_reg_file #(
    parameter int WIDTH           = 128,
    parameter int DEPTH           = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
    parameter int DEPTH_ADDR_SIZE = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    vec_reg_file_if.slave bus
);
    localparam logic [1:0] OP_VEC    = 2'b01;
    localparam logic [1:0] OP_SCALAR = 2'b10;
    localparam logic [1:0] OP_BCAST  = 2'b11;
    localparam logic [WIDTH_ADDR_SIZE-1:0] LAST_IDX = WIDTH_ADDR_SIZE'(WIDTH - 1);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    logic [DATA_WIDTH-1:0]       r_mem [DEPTH][WIDTH];

    logic                        w_wr_reg_ok;
    logic                        w_wr_idx_ok;
    logic [WIDTH-1:0]            w_wr_en;
    logic [DATA_WIDTH-1:0]       w_wr_elem [WIDTH];

    logic                        w_rd_reg_ok;
    logic                        w_rd_idx_ok;
    logic [DATA_WIDTH-1:0]       w_rd_row [WIDTH];
    logic [WIDTH*DATA_WIDTH-1:0] w_rd_next;
    logic                        w_rd_valid_next;
    logic [WIDTH*DATA_WIDTH-1:0] r_rd_data;
    logic                        r_rd_valid;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [WIDTH_ADDR_SIZE-1:0]  r_idx;
    logic [DEPTH_ADDR_SIZE-1:0]  r_stream_reg;
    logic [DATA_WIDTH-1:0]       r_stream_data;
    logic                        w_ld;
    logic [DEPTH_ADDR_SIZE-1:0]  w_ld_reg;
    logic [WIDTH_ADDR_SIZE-1:0]  w_ld_idx;
    logic [DATA_WIDTH-1:0]       w_ld_data;

    assign w_wr_reg_ok = 32'(bus.wr_reg) < DEPTH;
    assign w_wr_idx_ok = 32'(bus.wr_idx) < WIDTH;
    assign w_rd_reg_ok = 32'(bus.rd_reg) < DEPTH;
    assign w_rd_idx_ok = 32'(bus.rd_idx) < WIDTH;

    // Per-element write enable and data; SCALAR and BROADCAST both source element 0.
    // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch can form.
    always_comb begin
        w_wr_en = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_wr_elem[i] = (bus.wr_op == OP_VEC) ? bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH]
                                                 : bus.wr_data[DATA_WIDTH-1:0];
            if (w_wr_reg_ok) begin
                case (bus.wr_op)
                    OP_VEC, OP_BCAST: w_wr_en[i] = 1'b1;
                    OP_SCALAR:        w_wr_en[i] = w_wr_idx_ok && (bus.wr_idx == WIDTH_ADDR_SIZE'(i));
                    default:          w_wr_en[i] = 1'b0;
                endcase
            end
        end
    end

    // NOTE: storage must read back as zero after reset, so the whole array is cleared in the reset branch.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                for (int e = 0; e < WIDTH; e++) begin
                    r_mem[r][e] <= '0;
                end
            end
        end else begin
            for (int e = 0; e < WIDTH; e++) begin
                if (w_wr_en[e]) begin
                    r_mem[bus.wr_reg][e] <= w_wr_elem[e];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_rd_row[i] = w_rd_reg_ok ? r_mem[bus.rd_reg][i] : '0;
`ifdef VEC_REG_FILE_BYPASS_EN
            if (w_rd_reg_ok && (bus.rd_reg == bus.wr_reg) && w_wr_en[i]) begin
                w_rd_row[i] = w_wr_elem[i];
            end
`endif
        end
    end

    always_comb begin
        w_rd_next       = '0;
        w_rd_valid_next = 1'b0;
        case (bus.rd_op)
            OP_VEC: begin
                w_rd_valid_next = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    w_rd_next[i*DATA_WIDTH +: DATA_WIDTH] = w_rd_row[i];
                end
            end
            OP_SCALAR: begin
                w_rd_valid_next = 1'b1;
                if (w_rd_idx_ok) begin
                    w_rd_next[DATA_WIDTH-1:0] = w_rd_row[bus.rd_idx];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_data  <= w_rd_next;
            r_rd_valid <= w_rd_valid_next;
        end
    end

    // Drain control: a start in IDLE loads element 0; each accepted beat loads the next one.
    always_comb begin
        w_state_next = r_state;
        w_ld         = 1'b0;
        w_ld_reg     = r_stream_reg;
        w_ld_idx     = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (bus.stream_start) begin
                    w_state_next = ST_STREAM;
                    w_ld         = 1'b1;
                    w_ld_reg     = bus.stream_reg;
                    w_ld_idx     = '0;
                end
            end
            ST_STREAM: begin
                if (bus.stream_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_ld     = 1'b1;
                        w_ld_idx = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Loads see storage before any write landing on the same edge.
    assign w_ld_data = (32'(w_ld_reg) < DEPTH) ? r_mem[w_ld_reg][w_ld_idx] : '0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_stream_reg  <= '0;
            r_stream_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_ld) begin
                r_idx         <= w_ld_idx;
                r_stream_reg  <= w_ld_reg;
                r_stream_data <= w_ld_data;
            end
        end
    end

    assign bus.rd_data      = r_rd_data;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.stream_data  = r_stream_data;
    assign bus.stream_valid = (r_state == ST_STREAM);
    assign bus.stream_busy  = (r_state == ST_STREAM);
    assign bus.stream_last  = (r_state == ST_STREAM) && (r_idx == LAST_IDX);
endmodule

// File: tb/tb_vec_reg_file.sv
// Self-checking bench for vec_reg_file: table-driven write/read vectors plus
// hand-written drain, back-pressure and reset-mid-drain sequences.
module tb_vec_reg_file;
    localparam int W  = 128;
    localparam int D  = 8;
    localparam int DW = 32;

`ifdef VEC_REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [1:0] M_ALL  = 2'd0;
    localparam logic [1:0] M_RAMP = 2'd1;
    localparam logic [1:0] M_SCAL = 2'd2;

    typedef struct {
        logic [1:0]  wr_op;
        logic [2:0]  wr_reg;
        logic [6:0]  wr_idx;
        logic        wr_ramp;
        logic [31:0] wr_val;
        logic [1:0]  rd_op;
        logic [2:0]  rd_reg;
        logic [6:0]  rd_idx;
        logic        exp_valid;
        logic [1:0]  exp_mode;
        logic [31:0] exp_val;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    vec_reg_file_if #(.WIDTH(W), .DEPTH(D), .DATA_WIDTH(DW)) bus ();

    vec_reg_file #(.WIDTH(W), .DEPTH(D), .DATA_WIDTH(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_elem(input logic [1:0] mode, input logic [31:0] val,
                                             input logic valid, input int i);
        if (!valid) return 32'h0;
        case (mode)
            M_ALL:   return val;
            M_RAMP:  return val + 32'(i);
            default: return (i == 0) ? val : 32'h0;
        endcase
    endfunction

    task automatic check_rd(input string name, input logic [1:0] mode, input logic [31:0] val,
                            input logic valid);
        int bad = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (bus.rd_data[i*DW +: DW] !== exp_elem(mode, val, valid, i)) bad = i;
        end
        check({name, "_valid"}, 32'(bus.rd_valid), 32'(valid));
        check($sformatf("%s_elem%0d", name, bad), bus.rd_data[bad*DW +: DW],
              exp_elem(mode, val, valid, bad));
    endtask

    task automatic set_wr(input logic [1:0] op, input logic [2:0] rg, input logic [6:0] idx,
                          input logic ramp, input logic [31:0] val);
        bus.wr_op  = op;
        bus.wr_reg = rg;
        bus.wr_idx = idx;
        for (int i = 0; i < W; i++) begin
            if (ramp)        bus.wr_data[i*DW +: DW] = val + 32'(i);
            else if (i == 0) bus.wr_data[i*DW +: DW] = val;
            else             bus.wr_data[i*DW +: DW] = 32'hBAD0_0000 | 32'(i);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    vec_t vecs[18];

    initial begin
        int beat;
        int cyc;
        logic [31:0] held;
        logic stalled;
        logic [31:0] exp_beat [W];

        vecs[0]  = '{2'b00, 3'd0, 7'd0,   1'b0, 32'h0,        2'b01, 3'd3, 7'd0,   1'b1, M_ALL,  32'h0};
        vecs[1]  = '{2'b01, 3'd2, 7'd0,   1'b1, 32'h0,        2'b00, 3'd0, 7'd0,   1'b0, M_ALL,  32'h0};
        vecs[2]  = '{2'b00, 3'd0, 7'd0,   1'b0, 32'h0,        2'b10, 3'd2, 7'd5,   1'b1, M_SCAL, 32'd5};
        vecs[3]  = '{2'b11, 3'd7, 7'd0,   1'b0, 32'h3F800000, 2'b00, 3'd0, 7'd0,   1'b0, M_ALL,  32'h0};
        vecs[4]  = '{2'b00, 3'd0, 7'd0,   1'b0, 32'h0,        2'b01, 3'd7, 7'd0,   1'b1, M_ALL,  32'h3F800000};
        vecs[5]  = '{2'b10, 3'd1, 7'd4,   1'b0, 32'hDEAD,     2'b10, 3'd1, 7'd4,   1'b1, M_SCAL,
                     BYP ? 32'hDEAD : 32'h0};
        vecs[6]  = '{2'b00, 3'd0, 7'd0,   1'b0, 32'h0,        2'b10, 3'd1, 7'd4,   1'b1, M_SCAL, 32'hDEAD};
        vecs[7]  = '{2'b00, 3'd0, 7'd0,   1'b0, 32'h0,        2'b10, 3'd1, 7'd5,   1'b1, M_SCAL, 32'h0};
        vecs[8]  = '{2'b00, 3'd0, 7'd0,   1'b0, 32'h0,        2'b11, 3'd2, 7'd0,   1'b0, M_ALL,  32'h0};
        vecs[9]  = '{2'b01, 3'd5, 7'd0,   1'b1, 32'h100,      2'b01, 3'd5, 7'd0,   1'b1,
                     BYP ? M_RAMP : M_ALL, BYP ? 32'h100 : 32'h0};
        vecs[10] = '{2'b00, 3'd0, 7'd0,   1'b0, 32'h0,        2'b01, 3'd5, 7'd0,   1'b1, M_RAMP, 32'h100};
        vecs[11] = '{2'b11, 3'd5, 7'd0,   1'b0, 32'h40000000, 2'b10, 3'd5, 7'd127, 1'b1, M_SCAL,
                     BYP ? 32'h40000000 : 32'h17F};
        vecs[12] = '{2'b00, 3'd0, 7'd0,   1'b0, 32'h0,        2'b01, 3'd5, 7'd0,   1'b1, M_ALL,  32'h40000000};
        vecs[13] = '{2'b00, 3'd6, 7'd0,   1'b0, 32'h12345678, 2'b01, 3'd6, 7'd0,   1'b1, M_ALL,  32'h0};
        vecs[14] = '{2'b00, 3'd0, 7'd0,   1'b0, 32'h0,        2'b01, 3'd6, 7'd0,   1'b1, M_ALL,  32'h0};
        vecs[15] = '{2'b10, 3'd3, 7'd127, 1'b0, 32'h7F7F,     2'b10, 3'd3, 7'd127, 1'b1, M_SCAL,
                     BYP ? 32'h7F7F : 32'h0};
        vecs[16] = '{2'b00, 3'd0, 7'd0,   1'b0, 32'h0,        2'b10, 3'd3, 7'd127, 1'b1, M_SCAL, 32'h7F7F};
        vecs[17] = '{2'b00, 3'd0, 7'd0,   1'b0, 32'h0,        2'b10, 3'd3, 7'd126, 1'b1, M_SCAL, 32'h0};

        // Reset with a read and a drain request pending; both must be suppressed.
        reset_n = 1'b0;
        set_wr(2'b00, 3'd0, 7'd0, 1'b0, 32'h0);
        bus.rd_op        = 2'b01;
        bus.rd_reg       = 3'd0;
        bus.rd_idx       = 7'd0;
        bus.stream_start = 1'b1;
        bus.stream_reg   = 3'd0;
        bus.stream_ready = 1'b0;
        step();
        step();
        check_rd("reset_rd", M_ALL, 32'h0, 1'b0);
        check("reset_stream_valid", 32'(bus.stream_valid), 32'h0);
        check("reset_stream_busy",  32'(bus.stream_busy),  32'h0);
        check("reset_stream_last",  32'(bus.stream_last),  32'h0);
        check("reset_stream_data",  bus.stream_data,       32'h0);
        reset_n          = 1'b1;
        bus.stream_start = 1'b0;
        bus.rd_op        = 2'b00;

        for (int k = 0; k < 18; k++) begin
            set_wr(vecs[k].wr_op, vecs[k].wr_reg, vecs[k].wr_idx, vecs[k].wr_ramp, vecs[k].wr_val);
            bus.rd_op  = vecs[k].rd_op;
            bus.rd_reg = vecs[k].rd_reg;
            bus.rd_idx = vecs[k].rd_idx;
            step();
            check_rd($sformatf("vec%0d", k), vecs[k].exp_mode, vecs[k].exp_val, vecs[k].exp_valid);
        end
        bus.wr_op = 2'b00;
        bus.rd_op = 2'b00;

        // Drain reg 2 (elements 0..127) with ready toggling; writes land mid-drain.
        for (int i = 0; i < W; i++) exp_beat[i] = 32'(i);
        exp_beat[60] = 32'hBBBB;  // written before element 60 is loaded
        bus.stream_start = 1'b1;
        bus.stream_reg   = 3'd2;
        step();
        check("drain_busy_after_start",  32'(bus.stream_busy),  32'h1);
        bus.stream_reg = 3'd7;  // further starts while busy must be ignored
        beat    = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = 32'h0;
        while (beat < W && cyc < 1000) begin
            bus.stream_ready = (cyc % 2 == 0);
            check($sformatf("drain_valid_c%0d", cyc), 32'(bus.stream_valid), 32'h1);
            check($sformatf("drain_last_c%0d", cyc), 32'(bus.stream_last), 32'(beat == W - 1));
            if (stalled) check($sformatf("drain_hold_c%0d", cyc), bus.stream_data, held);
            bus.wr_op = 2'b00;
            if (bus.stream_ready) begin
                check($sformatf("drain_beat%0d", beat), bus.stream_data, exp_beat[beat]);
                if (beat == 50) set_wr(2'b10, 3'd2, 7'd51, 1'b0, 32'hAAAA);
                if (beat == 52) set_wr(2'b10, 3'd2, 7'd60, 1'b0, 32'hBBBB);
            end
            stalled = !bus.stream_ready;
            held    = bus.stream_data;
            step();
            if (!stalled) beat++;
            cyc++;
        end
        check("drain_beat_count", 32'(beat), 32'(W));
        bus.stream_start = 1'b0;
        bus.stream_ready = 1'b0;
        bus.wr_op        = 2'b00;
        check("drain_end_valid", 32'(bus.stream_valid), 32'h0);
        check("drain_end_busy",  32'(bus.stream_busy),  32'h0);
        check("drain_end_last",  32'(bus.stream_last),  32'h0);

        // Reset at beat 10 of a drain of reg 7.
        bus.stream_start = 1'b1;
        bus.stream_reg   = 3'd7;
        step();
        bus.stream_start = 1'b0;
        bus.stream_ready = 1'b1;
        beat = 0;
        cyc  = 0;
        while (beat < 10 && cyc < 100) begin
            if (bus.stream_valid) beat++;
            step();
            cyc++;
        end
        check("rst_drain_reached_beat10", 32'(beat), 32'd10);
        check("rst_drain_data_beat10", bus.stream_data, 32'h3F800000);
        reset_n    = 1'b0;
        bus.rd_op  = 2'b01;
        bus.rd_reg = 3'd7;
        step();
        check("rst_drain_valid", 32'(bus.stream_valid), 32'h0);
        check("rst_drain_busy",  32'(bus.stream_busy),  32'h0);
        check("rst_drain_last",  32'(bus.stream_last),  32'h0);
        check("rst_drain_data",  bus.stream_data,       32'h0);
        check_rd("rst_drain_rd", M_ALL, 32'h0, 1'b0);
        reset_n   = 1'b1;
        bus.rd_op = 2'b00;
        step();
        check("post_rst_valid", 32'(bus.stream_valid), 32'h0);
        check("post_rst_busy",  32'(bus.stream_busy),  32'h0);
        bus.stream_ready = 1'b0;
        bus.rd_op  = 2'b01;
        bus.rd_reg = 3'd7;
        step();
        check_rd("post_rst_reg7", M_ALL, 32'h0, 1'b1);
        bus.rd_reg = 3'd2;
        step();
        check_rd("post_rst_reg2", M_ALL, 32'h0, 1'b1);
        bus.rd_reg = 3'd5;
        step();
        check_rd("post_rst_reg5", M_ALL, 32'h0, 1'b1);
        bus.rd_op = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vec_reg_file.md
Name: vec_reg_file

Overview:
Multi-entry vector register file for the vector unit. It holds DEPTH vector registers of WIDTH elements, each element a DATA_WIDTH-bit IEEE-754 single-precision bit pattern.
- One write port: vector, scalar-element or broadcast writes.
- One registered read port: vector or scalar reads.
- An element-serial drain port with valid/ready handshake, used to stream a register out to the scalar/memory path one element per beat.

Parameters:
WIDTH, 128, elements per vector register
DEPTH, 8, number of vector registers
DATA_WIDTH, 32, bits per element
WIDTH_ADDR_SIZE, $clog2(WIDTH), element index width
DEPTH_ADDR_SIZE, $clog2(DEPTH), register index width

Ports:
clock  in  1  clock
reset_n  in  1  synchronous active-low reset
wr_op  in  2  00 DISABLE, 01 VEC, 10 SCALAR, 11 BROADCAST
wr_reg  in  DEPTH_ADDR_SIZE  destination register
wr_idx  in  WIDTH_ADDR_SIZE  element index for SCALAR
wr_data  in  WIDTH*DATA_WIDTH  write data; element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
rd_op  in  2  00 DISABLE, 01 VEC, 10 SCALAR, 11 reserved (treated as DISABLE)
rd_reg  in  DEPTH_ADDR_SIZE  source register
rd_idx  in  WIDTH_ADDR_SIZE  element index for SCALAR
rd_data  out  WIDTH*DATA_WIDTH  registered read data
rd_valid  out  1  rd_data holds a valid result
stream_start  in  1  begin draining stream_reg
stream_reg  in  DEPTH_ADDR_SIZE  register to drain
stream_data  out  DATA_WIDTH  current element
stream_valid  out  1  stream_data valid
stream_ready  in  1  consumer accepts beat
stream_last  out  1  current beat is element WIDTH-1
stream_busy  out  1  drain in progress

Behaviour:
Reset (reset_n=0 at posedge):
- All storage cleared to 0; FSM to IDLE.
- rd_data=0, rd_valid=0, stream_data=0, stream_valid=0, stream_last=0, stream_busy=0.
- Reset mid-drain aborts the drain immediately; no further beats are issued.

Write (takes effect at posedge):
- VEC: mem[wr_reg][i] <= wr_data element i, for all i.
- SCALAR: mem[wr_reg][wr_idx] <= wr_data element 0.
- BROADCAST: mem[wr_reg][i] <= wr_data element 0, for all i.
- wr_reg >= DEPTH or wr_idx >= WIDTH: write ignored.

Read (latency 1):
- rd_data and rd_valid register the result of the op sampled in the previous cycle.
- VEC: all elements of rd_reg.
- SCALAR: element 0 = mem[rd_reg][rd_idx]; all other elements 0.
- DISABLE/reserved: rd_data=0, rd_valid=0.
- Out-of-range rd_reg or rd_idx: rd_data=0, rd_valid=1.
- Read of a register written in the same cycle returns the pre-write contents (see Optional Feature).

Drain FSM, states IDLE and STREAM:
- IDLE, stream_start=1: latch stream_reg, set index=0, load stream_data=mem[reg][0], go to STREAM. stream_valid=1 from the next cycle.
- STREAM, stream_valid and stream_ready both high, index < WIDTH-1: index++, load the next element into stream_data. stream_valid stays 1, so back-to-back beats run at one per cycle.
- STREAM, handshake with index = WIDTH-1: go to IDLE; stream_valid=0 and stream_last=0 next cycle.
- stream_ready low: stream_data, stream_valid and index hold.
- stream_last = stream_valid && index == WIDTH-1.
- stream_busy = (state == STREAM).
- stream_start while busy is ignored, including in the cycle of the final handshake.
- Out-of-range stream_reg: drain proceeds with all-zero data.
- Elements are loaded from live storage at load time. A write landing in the same cycle as an element load does not affect that load; a write that lands earlier is visible to every element not yet loaded.

Optional Feature:
VEC_REG_FILE_BYPASS_EN
- Defined: if wr_op writes the register/element that a same-cycle read selects, rd_data next cycle reflects the new data. Applies per element for SCALAR and BROADCAST.
- Undefined: rd_data returns pre-write contents. The drain port never bypasses in either configuration.

Test Plan:
- Reset, then VEC read of reg 3 -> rd_data all 0, rd_valid=1 one cycle later.
- VEC write reg 2 with element i = i; next cycle SCALAR read reg 2, idx 5 -> rd_data element 0 = 5, all others 0.
- BROADCAST 0x3F800000 to reg 7, then VEC read -> all 128 elements = 0x3F800000.
- Same-cycle SCALAR write reg 1 idx 4 = 0xDEAD and SCALAR read reg 1 idx 4 -> result 0 without the macro, 0xDEAD with it.
- Drain reg 2 with stream_ready toggling 1,0,1,...
  - Expect 128 beats with values 0..127 in order.
  - Data holds while ready is low.
  - stream_last only on value 127; busy drops the cycle after the final handshake.
- Assert reset_n=0 at beat 10 of a drain -> next cycle stream_valid=0, stream_busy=0, and storage reads back 0.
